fifo_rr_sched: RTL and testbench

Round-robin drain scheduler for a bank of N_REQ request FIFOs sharing one downstream consumer. It observes each FIFO's `empty` flag and head data, issues at most one `pop` per cycle, and registers the popped element into a single valid/ready output stage tagged with its source index. A per-requester burst quantum lets a requester keep the grant for up to QUANTUM consecutive pops. It sits between the per-source `fifo` instances and the shared downstream datapath.

---
 rtl/fifo_rr_sched_pkg.sv | 4 +
 rtl/fifo_rr_sched_if.sv | 25 ++
 rtl/fifo_rr_sched_rr_pick.sv | 26 ++
 rtl/fifo_rr_sched.sv | 92 +++++++++
 tb/tb_fifo_rr_sched.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rr_sched_pkg.sv
// rtl/fifo_rr_sched_pkg.sv - shared types for the round-robin FIFO drain scheduler
package fifo_sched_pkg;
   typedef enum logic {IDLE, BURST} sched_st_e;
endpackage

// File: rtl/fifo_rr_sched_if.sv
// rtl/fifo_rr_sched_if.sv - FIFO-bank side and output-stage side signals of the scheduler
interface fifo_rr_sched_if #(
   parameter int N_REQ      = 4,
   parameter int ELEM_WIDTH = 32
);
   localparam int SRC_W = $clog2(N_REQ);

   logic [N_REQ-1:0]                 q_empty;
   logic [N_REQ-1:0][ELEM_WIDTH-1:0] q_data;
   logic [N_REQ-1:0]                 q_pop;
   logic                             out_valid;
   logic                             out_ready;
   logic [ELEM_WIDTH-1:0]            out_data;
   logic [SRC_W-1:0]                 out_src;

   modport master (
      input  q_empty, q_data, out_ready,
      output q_pop, out_valid, out_data, out_src
   );

   modport slave (
      output q_empty, q_data, out_ready,
      input  q_pop, out_valid, out_data, out_src
   );
endinterface

// File: rtl/fifo_rr_sched_rr_pick.sv
// rtl/fifo_rr_sched_rr_pick.sv - rotate-priority encoder: first set request at or after i_ptr
module rr_pick #(
   parameter  int N_REQ = 4,
   localparam int SRC_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [SRC_W-1:0] i_ptr,
   output logic             o_found,
   output logic [SRC_W-1:0] o_sel
);
   always_comb begin
      int idx;
      o_found = 1'b0;
      o_sel   = '0;
      idx     = 0;
      // Scan farthest-first so the request closest to i_ptr wins last.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(i_ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (i_req[SRC_W'(idx)]) begin
            o_found = 1'b1;
            o_sel   = SRC_W'(idx);
         end
      end
   end
endmodule

// File: rtl/fifo_rr_sched.sv
// rtl/fifo_rr_sched.sv - round-robin drain of N_REQ FIFOs into one registered valid/ready stage
module fifo_rr_sched
   import fifo_sched_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int ELEM_WIDTH = 32,
   parameter int QUANTUM    = 1
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              init,
   input  logic              en,
   fifo_rr_sched_if.master   bus
);
   localparam int SRC_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(QUANTUM + 1);
   localparam logic [CNT_W-1:0] QMAX = CNT_W'(QUANTUM);

   sched_st_e             r_st;
   logic [SRC_W-1:0]      r_owner;
   logic [SRC_W-1:0]      r_ptr;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_valid;
   logic [ELEM_WIDTH-1:0] r_data;
   logic [SRC_W-1:0]      r_src;

   logic                  w_load;
   logic                  w_cont;
   logic                  w_found;
   logic                  w_fire;
   logic [N_REQ-1:0]      w_req;
   logic [N_REQ-1:0]      w_pop;
   logic [SRC_W-1:0]      w_pick;
   logic [SRC_W-1:0]      w_sel;
   logic [SRC_W-1:0]      w_ptr_nxt;

   assign w_req     = ~bus.q_empty;
   assign w_load    = en && (!r_valid || bus.out_ready);
   assign w_cont    = (r_st == BURST) && !bus.q_empty[r_owner] && (r_cnt < QMAX);
   assign w_sel     = w_cont ? r_owner : w_pick;
   assign w_fire    = arst_n && !init && w_load && (w_cont || w_found);
   assign w_ptr_nxt = (w_pick == SRC_W'(N_REQ - 1)) ? '0 : w_pick + 1'b1;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .i_req   (w_req),
      .i_ptr   (r_ptr),
      .o_found (w_found),
      .o_sel   (w_pick)
   );

   always_comb begin
      w_pop = '0;
      if (w_fire) w_pop[w_sel] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!arst_n || init) begin
         r_st    <= IDLE;
         r_owner <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_src   <= '0;
      end else if (w_load) begin
         if (w_cont || w_found) begin
            r_valid <= 1'b1;
            r_data  <= bus.q_data[w_sel];
            r_src   <= w_sel;
            if (w_cont) begin
               r_cnt <= r_cnt + 1'b1;
            end else begin
               r_owner <= w_pick;
               r_cnt   <= CNT_W'(1);
               r_ptr   <= w_ptr_nxt;
               r_st    <= BURST;
            end
         end else begin
            r_valid <= 1'b0;
            r_st    <= IDLE;
         end
      end else if (r_valid && bus.out_ready) begin
         // Scheduling disabled: the held element can still drain downstream.
         r_valid <= 1'b0;
      end
   end

   assign bus.q_pop     = w_pop;
   assign bus.out_valid = r_valid;
   assign bus.out_data  = r_data;
   assign bus.out_src   = r_src;
endmodule

// File: tb/tb_fifo_rr_sched.sv
// tb/tb_fifo_rr_sched.sv - directed bench for fifo_rr_sched with a behavioural FIFO bank
module tb_fifo_rr_sched;
   localparam int N = 4;
   localparam int W = 32;

   typedef struct {
      logic        ready;
      logic [3:0]  pop;
      logic        valid;
      logic [1:0]  src;
      logic [31:0] data;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic arst_n, init, en, ready, use_b;
   logic [31:0] mem [N][8];
   logic [2:0]  hd [N];
   int          cnt [N];
   logic [N-1:0]        w_empty;
   logic [N-1:0][W-1:0] w_data;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_empty[i] = (cnt[i] == 0);
         w_data[i]  = mem[i][hd[i]];
      end
   end

   fifo_rr_sched_if #(.N_REQ(N), .ELEM_WIDTH(W)) ifa ();
   fifo_rr_sched_if #(.N_REQ(N), .ELEM_WIDTH(W)) ifb ();

   assign ifa.q_empty   = w_empty;
   assign ifa.q_data    = w_data;
   assign ifa.out_ready = ready;
   assign ifb.q_empty   = w_empty;
   assign ifb.q_data    = w_data;
   assign ifb.out_ready = ready;

   fifo_rr_sched #(.N_REQ(N), .ELEM_WIDTH(W), .QUANTUM(2)) dut_a (
      .clk(clk), .arst_n(arst_n), .init(init), .en(en), .bus(ifa.master)
   );
   fifo_rr_sched #(.N_REQ(N), .ELEM_WIDTH(W), .QUANTUM(1)) dut_b (
      .clk(clk), .arst_n(arst_n), .init(init), .en(en), .bus(ifb.master)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [3:0]  s_pop;
   logic        s_valid;
   logic [1:0]  s_src;
   logic [31:0] s_data;
   vec_t        tab [32];
   int          nv = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Sample pre-edge outputs, then retire popped elements from the model after the edge.
   task automatic cycle();
      @(negedge clk);
      if (use_b) begin
         s_pop = ifb.q_pop; s_valid = ifb.out_valid; s_src = ifb.out_src; s_data = ifb.out_data;
      end else begin
         s_pop = ifa.q_pop; s_valid = ifa.out_valid; s_src = ifa.out_src; s_data = ifa.out_data;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (s_pop[i] && cnt[i] > 0) begin
            hd[i]  = hd[i] + 3'd1;
            cnt[i] = cnt[i] - 1;
         end
      end
   endtask

   task automatic fill(input int i, input int n);
      for (int k = 0; k < n; k++) mem[i][3'(int'(hd[i]) + cnt[i] + k)] = 32'(i * 256 + k);
      cnt[i] = cnt[i] + n;
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         cnt[i] = 0;
         hd[i]  = '0;
      end
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      clear_model();
      cycle();
      cycle();
      arst_n = 1'b1;
   endtask

   task automatic add(input logic r, input logic [3:0] p, input logic v,
                      input logic [1:0] s, input logic [31:0] d);
      tab[nv] = '{ready: r, pop: p, valid: v, src: s, data: d};
      nv++;
   endtask

   task automatic expect_cyc(input string nm, input logic [3:0] p, input logic v,
                             input logic [1:0] s, input logic [31:0] d);
      cycle();
      chk({nm, " pop"}, 32'(s_pop), 32'(p));
      chk({nm, " valid"}, 32'(s_valid), 32'(v));
      if (v) begin
         chk({nm, " src"}, 32'(s_src), 32'(s));
         chk({nm, " data"}, s_data, d);
      end
   endtask

   task automatic run_table(input int lo, input int hi);
      for (int k = lo; k < hi; k++) begin
         ready = tab[k].ready;
         expect_cyc($sformatf("vec%0d", k), tab[k].pop, tab[k].valid, tab[k].src, tab[k].data);
      end
      ready = 1'b1;
   endtask

   initial begin
      arst_n = 1'b0; init = 1'b0; en = 1'b1; ready = 1'b1; use_b = 1'b0;
      for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) mem[i][k] = '0;
      clear_model();

      // QUANTUM=2: FIFO0/FIFO2 x3 each -> 0,0,2,2,0,2
      add(1, 4'b0001, 0, 0, 32'h000); add(1, 4'b0001, 1, 0, 32'h000);
      add(1, 4'b0100, 1, 0, 32'h001); add(1, 4'b0100, 1, 2, 32'h200);
      add(1, 4'b0001, 1, 2, 32'h201); add(1, 4'b0100, 1, 0, 32'h002);
      add(1, 4'b0000, 1, 2, 32'h202); add(1, 4'b0000, 0, 0, 32'h000);
      // FIFO1 x1, FIFO3 x2 -> 1,3,3 with no gap
      add(1, 4'b0010, 0, 0, 32'h000); add(1, 4'b1000, 1, 1, 32'h100);
      add(1, 4'b1000, 1, 3, 32'h300); add(1, 4'b0000, 1, 3, 32'h301);
      add(1, 4'b0000, 0, 0, 32'h000);
      // backpressure: FIFO0 x3, FIFO1 x2, 5 stalled cycles
      add(1, 4'b0001, 0, 0, 32'h000);
      for (int k = 0; k < 5; k++) add(0, 4'b0000, 1, 0, 32'h000);
      add(1, 4'b0001, 1, 0, 32'h000); add(1, 4'b0010, 1, 0, 32'h001);
      add(1, 4'b0010, 1, 1, 32'h100); add(1, 4'b0001, 1, 1, 32'h101);
      add(1, 4'b0000, 1, 0, 32'h002); add(1, 4'b0000, 0, 0, 32'h000);

      // reset with all FIFOs non-empty
      for (int i = 0; i < N; i++) fill(i, 1);
      expect_cyc("rst0", 4'b0000, 0, 0, 0);
      chk("rst0 src", 32'(s_src), 32'd0);
      chk("rst0 data", s_data, 32'd0);
      expect_cyc("rst1", 4'b0000, 0, 0, 0);
      arst_n = 1'b1;
      expect_cyc("rel0", 4'b0001, 0, 0, 0);
      expect_cyc("rel1", 4'b0010, 1, 0, 32'h000);

      do_reset(); fill(0, 3); fill(2, 3); run_table(0, 8);
      do_reset(); fill(1, 1); fill(3, 2); run_table(8, 13);
      do_reset(); fill(0, 3); fill(1, 2); run_table(13, 25);

      // wrap with QUANTUM=1
      do_reset();
      use_b = 1'b1;
      fill(3, 1);
      expect_cyc("wrap0", 4'b1000, 0, 0, 0);
      fill(0, 1);
      expect_cyc("wrap1", 4'b0001, 1, 3, 32'h300);
      expect_cyc("wrap2", 4'b0000, 1, 0, 32'h000);
      expect_cyc("wrap3", 4'b0000, 0, 0, 0);
      use_b = 1'b0;

      // init mid-stream restarts search at FIFO0
      do_reset();
      fill(1, 2);
      expect_cyc("init0", 4'b0010, 0, 0, 0);
      expect_cyc("init1", 4'b0010, 1, 1, 32'h100);
      fill(0, 1); fill(3, 1);
      init = 1'b1;
      expect_cyc("init2", 4'b0000, 1, 1, 32'h101);
      init = 1'b0;
      expect_cyc("init3", 4'b0001, 0, 0, 0);
      expect_cyc("init4", 4'b1000, 1, 0, 32'h000);
      expect_cyc("init5", 4'b0000, 1, 3, 32'h300);

      // en low blocks pops but the held element still drains
      fill(2, 1);
      en = 1'b0;
      expect_cyc("en0", 4'b0000, 0, 0, 0);
      expect_cyc("en1", 4'b0000, 0, 0, 0);
      en = 1'b1;
      expect_cyc("en2", 4'b0100, 0, 0, 0);
      en = 1'b0;
      expect_cyc("en3", 4'b0000, 1, 2, 32'h200);
      expect_cyc("en4", 4'b0000, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
